// File: rtl/regfile_seq_ctrl_if.sv
// ============================================================================
// Module      : regfile_seq_ctrl_if
// Description : Control and regfile-port bundle for the Fibonacci-style
//               register-file fill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_seq_ctrl_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);

  // Requester and ALU side
  logic          start;
  logic          abort;
  logic [AW-1:0] count;
  logic [DW-1:0] init_a;
  logic [DW-1:0] init_b;
  logic          alu_ovf;

  // Register file, ALU control and status
  logic [AW-1:0] r1_addr;
  logic [AW-1:0] r2_addr;
  logic [AW-1:0] r3_addr;
  logic          r3_wr;
  logic          wr_sel;
  logic [DW-1:0] init_data;
  logic [4:0]    alu_op;
  logic [5:0]    state;
  logic          busy;
  logic          done;
  logic          err;
  logic          ovf;

  modport master (
    output start, abort, count, init_a, init_b, alu_ovf,
    input  r1_addr, r2_addr, r3_addr, r3_wr, wr_sel, init_data, alu_op,
    input  state, busy, done, err, ovf
  );

  modport slave (
    input  start, abort, count, init_a, init_b, alu_ovf,
    output r1_addr, r2_addr, r3_addr, r3_wr, wr_sel, init_data, alu_op,
    output state, busy, done, err, ovf
  );

endinterface

`default_nettype wire

// File: rtl/regfile_seq_ctrl.sv
// ============================================================================
// Module      : regfile_seq_ctrl
// Description : Seeds r1/r2 and fills r3..rN with r[k] = r[k-2] + r[k-1].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_seq_ctrl #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32,
  parameter logic [4:0]  ALU_ADD = 5'b00001
) (
  input  wire logic         clk,
  input  wire logic         rst,
  regfile_seq_ctrl_if.slave bus
);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    INIT_A = 6'b000010,
    INIT_B = 6'b000100,
    READ   = 6'b001000,
    WRITE  = 6'b010000,
    DONE   = 6'b100000
  } state_e;

  localparam logic [AW-1:0] C_MIN_COUNT = AW'(2);
  localparam logic [AW-1:0] C_K_FIRST   = AW'(3);
  localparam logic [AW-1:0] C_ADDR_R1   = AW'(1);
  localparam logic [AW-1:0] C_ADDR_R2   = AW'(2);

  state_e        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] k_q, k_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic [AW-1:0] r1_addr_w;
  logic [AW-1:0] r2_addr_w;
  logic [AW-1:0] r3_addr_w;
  logic          r3_wr_w;
  logic          wr_sel_w;
  logic [DW-1:0] init_data_w;
  logic [4:0]    alu_op_w;
  logic          busy_w;

  // Next-state logic; abort only matters in the four busy states.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count >= C_MIN_COUNT) begin
            n_d     = bus.count;
            k_d     = C_K_FIRST;
            ovf_d   = 1'b0;
            state_d = INIT_A;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      INIT_A: begin
        state_d = bus.abort ? IDLE : INIT_B;
      end
      INIT_B: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (n_q == C_MIN_COUNT) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = bus.abort ? IDLE : WRITE;
      end
      WRITE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          if (bus.alu_ovf) begin
            ovf_d = 1'b1;
          end
          if (k_q == n_q) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + AW'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Port decode from the registered state; seeds pass through live so a
  // late change of init_a/init_b is still picked up in its own write cycle.
  always_comb begin
    r1_addr_w   = '0;
    r2_addr_w   = '0;
    r3_addr_w   = '0;
    r3_wr_w     = 1'b0;
    wr_sel_w    = 1'b0;
    init_data_w = '0;
    alu_op_w    = '0;
    case (state_q)
      INIT_A: begin
        r3_addr_w   = C_ADDR_R1;
        wr_sel_w    = 1'b1;
        init_data_w = bus.init_a;
        r3_wr_w     = ~bus.abort;
      end
      INIT_B: begin
        r3_addr_w   = C_ADDR_R2;
        wr_sel_w    = 1'b1;
        init_data_w = bus.init_b;
        r3_wr_w     = ~bus.abort;
      end
      READ: begin
        r1_addr_w   = k_q - AW'(2);
        r2_addr_w   = k_q - AW'(1);
        r3_addr_w   = k_q;
        alu_op_w    = ALU_ADD;
      end
      WRITE: begin
        r1_addr_w   = k_q - AW'(2);
        r2_addr_w   = k_q - AW'(1);
        r3_addr_w   = k_q;
        alu_op_w    = ALU_ADD;
        r3_wr_w     = ~bus.abort;
      end
      default: begin
        r3_wr_w     = 1'b0;
      end
    endcase
  end

  assign busy_w        = (state_q == INIT_A) || (state_q == INIT_B) ||
                         (state_q == READ)   || (state_q == WRITE);

  assign bus.r1_addr   = r1_addr_w;
  assign bus.r2_addr   = r2_addr_w;
  assign bus.r3_addr   = r3_addr_w;
  assign bus.r3_wr     = r3_wr_w;
  assign bus.wr_sel    = wr_sel_w;
  assign bus.init_data = init_data_w;
  assign bus.alu_op    = alu_op_w;
  assign bus.state     = state_q;
  assign bus.busy      = busy_w;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: doc/regfile_seq_ctrl.md
REGFILE_SEQ_CTRL -- requirements
Module: regfile_seq_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  AW, 5, register address width.
  DW, 32, data width.
  ALU_ADD, 5'b00001, alu_op code driven for addition.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  reset; synchronous, active-high.
  start  in  1  request sequence run; sampled only in IDLE.
  abort  in  1  cancel a running sequence.
  count  in  AW  number of registers to fill, legal 2..31.
  init_a  in  DW  seed written to r1.
  init_b  in  DW  seed written to r2.
  alu_ovf  in  1  ALU overflow flag for the current add.
  r1_addr  out  AW  regfile read port 1 address.
  r2_addr  out  AW  regfile read port 2 address.
  r3_addr  out  AW  regfile write address.
  r3_wr  out  1  regfile write enable.
  wr_sel  out  1  write data select: 1 = init_data, 0 = ALU result.
  init_data  out  DW  seed value presented for write.
  alu_op  out  5  ALU operation code.
  state  out  6  one-hot state, for debug.
  busy  out  1  sequence in progress.
  done  out  1  one-cycle completion pulse.
  err  out  1  one-cycle illegal-count pulse.
  ovf  out  1  sticky overflow seen during the current or last run.

Function
REQ-003 States, one-hot on state: IDLE=000001, INIT_A=000010, INIT_B=000100, READ=001000, WRITE=010000, DONE=100000.
REQ-004 IDLE with start=1 and 2<=count<=31: latch count into N, clear ovf, set k=3, go to INIT_A.
REQ-005 IDLE with start=1 and count<2: pulse err for 1 cycle and stay in IDLE; ovf unchanged.
REQ-006 INIT_A: r3_addr=1, wr_sel=1, init_data=init_a, r3_wr=1; next state INIT_B.
REQ-007 INIT_B: r3_addr=2, wr_sel=1, init_data=init_b, r3_wr=1; next state DONE if N==2, else READ.
REQ-008 READ: r1_addr=k-2, r2_addr=k-1, r3_addr=k, alu_op=ALU_ADD, wr_sel=0, r3_wr=0; next state WRITE.
REQ-009 WRITE: same addresses, alu_op and wr_sel as READ, r3_wr=1; ovf is set if alu_ovf=1; if k==N go to DONE, else k=k+1 and go to READ.
REQ-010 DONE: done=1 for exactly 1 cycle, r3_wr=0; next state IDLE.
REQ-011 busy=1 in INIT_A, INIT_B, READ and WRITE; busy=0 in IDLE and DONE.
REQ-012 Outside REQ-006 to REQ-009: r3_wr=0, wr_sel=0, all addresses 0, alu_op=0, init_data=0.
REQ-013 Latency from start acceptance at cycle T: first write at T+1, done at T+3+2*(N-2).
REQ-014 start while busy or in DONE is ignored; count, init_a and init_b changes after acceptance do not affect the run, except that init_a and init_b are read live in INIT_A and INIT_B.
REQ-015 abort=1 in any busy state: next state IDLE, r3_wr=0 that cycle, no done pulse; ovf holds its value; abort in IDLE or DONE has no effect.
REQ-016 rst and abort both high: rst wins.
REQ-017 k never exceeds N and never wraps; register 0 is never written.

Reset
REQ-018 With rst=1 at a clock edge, the next state is IDLE; N=0, k=0, ovf=0, and done, err, busy and r3_wr are 0; all address and data outputs are 0.
REQ-019 Reset mid-run: the write in progress is suppressed from the next cycle; no done pulse.

Verification
REQ-020 count=5, init_a=1, init_b=1, start pulse -> writes r1=1, r2=1, r3=2, r4=3, r5=5; done at T+9; ovf=0.
REQ-021 count=2, start -> two writes (r1, r2), done at T+3, no READ state visited.
REQ-022 count=1, start -> err pulse for 1 cycle, state stays 000001, no writes.
REQ-023 count=31, init_a=32'h7FFFFFFF, init_b=1, alu_ovf driven by the ALU -> ovf=1 after the first add; done at T+61.
REQ-024 abort asserted in the 2nd READ of a count=6 run -> IDLE next cycle, no further r3_wr, no done; a new start is accepted next cycle.
REQ-025 rst asserted during WRITE, with start held high -> IDLE, all outputs 0; the run restarts only after rst falls.
